latch_ex_mem: RTL and testbench
===============================

# latch_ex_mem

EX/MEM pipeline register for the five-stage MIPS core. Captures the ALU result, store data, the destination register selected by the rt/rd destination mux, and the MEM/WB control bits at the end of the execute stage, and presents them to the memory stage and the forwarding unit. Holds under the debug unit's step/run enable, inserts a bubble on flush, and tracks the halt instruction as it drains toward writeback.

## Interface
Parameters:
- BITS_SIZE, 32, datapath width (ALU result, store data).
- BITS_REGS, 5, register-index width.

Ports:
- i_clk  in  1  core clock; all state updates on rising edge.
- i_reset  in  1  reset, synchronous and active-high.
- i_enable  in  1  debug-unit run/step enable; 0 freezes the latch.
- i_flush  in  1  replace the incoming instruction with a bubble.
- i_valid  in  1  EX stage holds a real instruction (0 = bubble).
- i_alu_result  in  BITS_SIZE  ALU output / effective address.
- i_store_data  in  BITS_SIZE  forwarded rt value for stores.
- i_mux_register_rd  in  BITS_REGS  destination register from the rt/rd mux.
- i_ctl_reg_write, i_ctl_mem_read, i_ctl_mem_write, i_ctl_mem_to_reg  in  1 each  control bits.
- i_ctl_mem_size  in  2  00 byte, 01 half, 11 word (10 treated as word).
- i_ctl_mem_unsigned  in  1  zero-extend loads.
- i_halt  in  1  EX stage holds HALT.
- o_valid, o_alu_result, o_store_data, o_register_rd, o_ctl_* , o_halt  out  same widths  registered copies.
- o_halt_drained  out  1  HALT has left MEM and WB has completed.

## Operation
- Per edge, priority: i_reset > (i_enable==0: hold all state) > i_flush (load bubble) > load inputs.
- Bubble: o_valid=0; all o_ctl_* =0, o_halt=0; data fields and o_register_rd=0.
- Load: all fields copied; every o_ctl_* bit and o_halt ANDed with i_valid.
- $zero rule: if i_mux_register_rd==0, o_ctl_reg_write is captured as 0 (forwarding never matches $zero).
- Load/store conflict: i_ctl_mem_read and i_ctl_mem_write both 1 → capture both as 0 and keep o_valid; never drive both outputs high.
- o_ctl_mem_size value 10 is normalised to 11 on capture.
- Halt drain: 2-bit down-counter. Loaded with 2 when o_halt is set on an enabled edge, then decrements on each enabled edge; o_halt_drained=1 when the counter reaches 0 after having been loaded, sticky until reset. Only reset clears o_halt_drained.
- Flush on the same edge HALT would be captured: the flush wins; the counter is not loaded.

## Timing
- Latency: exactly 1 enabled clock from inputs to outputs.
- Reset values: every output 0, including o_halt_drained; counter idle.
- i_enable low: outputs and counter frozen regardless of i_flush; a flush must be held until an enabled edge.
- Reset mid-drain: the counter and sticky flag clear on the same edge.
- No combinational path from any input to any output.

## Structure
- Shared package (core-wide): mem-size encodings (BYTE=00, HALF=01, WORD=11), and the bubble constant for the control bundle, reused by the ID/EX and MEM/WB latches.
- A single module with no sub-modules. The drain counter is small enough to stay inline.

## Test plan
- Reset: assert i_reset one cycle with all inputs non-zero → all outputs 0 next edge.
- Load: i_valid=1, alu=0x0000_1004, rd=5, reg_write=1 → next edge o_alu_result=0x1004, o_register_rd=5, o_ctl_reg_write=1.
- $zero: rd=0, reg_write=1 → o_ctl_reg_write=0, o_valid=1.
- Enable/flush: i_enable=0 with i_flush=1 for 3 cycles → outputs unchanged. Then i_enable=1, i_flush=1 → bubble (o_valid=0, all ctl 0).
- Conflict: mem_read=1, mem_write=1, size=10 → both read and write outputs 0, o_ctl_mem_size=11.
- Halt: i_halt=1, i_valid=1 → o_halt next edge, o_halt_drained=1 two enabled edges later and sticky. Repeat with i_enable toggling: drained is delayed by exactly the number of disabled cycles. Repeat with i_flush on the capture edge: drained never asserts.

Source files
------------

// File: rtl/latch_ex_mem_pkg.sv
// rtl/latch_ex_mem_pkg.sv - core-wide pipeline-latch encodings and control bundle
// Shared by the ID/EX, EX/MEM and MEM/WB latches.
package latch_ex_mem_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] mem_size;
    logic       mem_unsigned;
  } ctl_bundle_t;

  localparam ctl_bundle_t CTL_BUBBLE = '0;

  // The unused 10 encoding is folded onto word so downstream decoders see three values only.
  function automatic logic [1:0] normalise_mem_size(input logic [1:0] size);
    return (size == 2'b10) ? MEM_SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/latch_ex_mem.sv
// rtl/latch_ex_mem.sv - EX/MEM pipeline register with bubble insertion and halt-drain tracking
// Feeds the memory stage and the forwarding unit; frozen while the debug unit holds i_enable low.
module latch_ex_mem
  import latch_ex_mem_pkg::*;
#(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [BITS_SIZE-1:0] i_alu_result,
  input  logic [BITS_SIZE-1:0] i_store_data,
  input  logic [BITS_REGS-1:0] i_mux_register_rd,
  input  logic                 i_ctl_reg_write,
  input  logic                 i_ctl_mem_read,
  input  logic                 i_ctl_mem_write,
  input  logic                 i_ctl_mem_to_reg,
  input  logic [1:0]           i_ctl_mem_size,
  input  logic                 i_ctl_mem_unsigned,
  input  logic                 i_halt,
  output logic                 o_valid,
  output logic [BITS_SIZE-1:0] o_alu_result,
  output logic [BITS_SIZE-1:0] o_store_data,
  output logic [BITS_REGS-1:0] o_register_rd,
  output logic                 o_ctl_reg_write,
  output logic                 o_ctl_mem_read,
  output logic                 o_ctl_mem_write,
  output logic                 o_ctl_mem_to_reg,
  output logic [1:0]           o_ctl_mem_size,
  output logic                 o_ctl_mem_unsigned,
  output logic                 o_halt,
  output logic                 o_halt_drained
);

  logic                 r_valid;
  logic [BITS_SIZE-1:0] r_alu_result;
  logic [BITS_SIZE-1:0] r_store_data;
  logic [BITS_REGS-1:0] r_register_rd;
  ctl_bundle_t          r_ctl;
  logic                 r_halt;
  logic [1:0]           r_drain_cnt;
  logic                 r_halt_drained;

  ctl_bundle_t          w_ctl;
  logic                 w_conflict;
  logic                 w_halt_capture;

  always_comb begin
    w_conflict         = i_ctl_mem_read & i_ctl_mem_write;
    w_ctl              = CTL_BUBBLE;
    // Writes to $zero are dropped here so the forwarding unit never matches register 0.
    w_ctl.reg_write    = i_valid & i_ctl_reg_write & (i_mux_register_rd != '0);
    w_ctl.mem_read     = i_valid & i_ctl_mem_read & ~w_conflict;
    w_ctl.mem_write    = i_valid & i_ctl_mem_write & ~w_conflict;
    w_ctl.mem_to_reg   = i_valid & i_ctl_mem_to_reg;
    w_ctl.mem_size     = {2{i_valid}} & normalise_mem_size(i_ctl_mem_size);
    w_ctl.mem_unsigned = i_valid & i_ctl_mem_unsigned;
    w_halt_capture     = i_valid & i_halt & ~i_flush;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid        <= 1'b0;
      r_alu_result   <= '0;
      r_store_data   <= '0;
      r_register_rd  <= '0;
      r_ctl          <= CTL_BUBBLE;
      r_halt         <= 1'b0;
      r_drain_cnt    <= 2'd0;
      r_halt_drained <= 1'b0;
    end else if (i_enable) begin
      if (i_flush) begin
        r_valid       <= 1'b0;
        r_alu_result  <= '0;
        r_store_data  <= '0;
        r_register_rd <= '0;
        r_ctl         <= CTL_BUBBLE;
        r_halt        <= 1'b0;
      end else begin
        r_valid       <= i_valid;
        r_alu_result  <= i_alu_result;
        r_store_data  <= i_store_data;
        r_register_rd <= i_mux_register_rd;
        r_ctl         <= w_ctl;
        r_halt        <= i_valid & i_halt;
      end

      // Two further enabled edges after capture cover HALT's trip through MEM and WB.
      if (w_halt_capture) begin
        r_drain_cnt <= 2'd2;
      end else if (r_drain_cnt != 2'd0) begin
        r_drain_cnt <= r_drain_cnt - 2'd1;
        if (r_drain_cnt == 2'd1) begin
          r_halt_drained <= 1'b1;
        end
      end
    end
  end

  assign o_valid            = r_valid;
  assign o_alu_result       = r_alu_result;
  assign o_store_data       = r_store_data;
  assign o_register_rd      = r_register_rd;
  assign o_ctl_reg_write    = r_ctl.reg_write;
  assign o_ctl_mem_read     = r_ctl.mem_read;
  assign o_ctl_mem_write    = r_ctl.mem_write;
  assign o_ctl_mem_to_reg   = r_ctl.mem_to_reg;
  assign o_ctl_mem_size     = r_ctl.mem_size;
  assign o_ctl_mem_unsigned = r_ctl.mem_unsigned;
  assign o_halt             = r_halt;
  assign o_halt_drained     = r_halt_drained;

endmodule

// File: tb/tb_latch_ex_mem.sv
// tb/tb_latch_ex_mem.sv - directed scoreboard bench for the EX/MEM latch
module tb_latch_ex_mem;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic [1:0]  size;
    logic        uns;
    logic        halt;
    logic        drained;
  } out_t;

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable, i_flush, i_valid;
  logic [31:0] i_alu_result, i_store_data;
  logic [4:0]  i_mux_register_rd;
  logic        i_ctl_reg_write, i_ctl_mem_read, i_ctl_mem_write, i_ctl_mem_to_reg;
  logic [1:0]  i_ctl_mem_size;
  logic        i_ctl_mem_unsigned, i_halt;
  logic        o_valid;
  logic [31:0] o_alu_result, o_store_data;
  logic [4:0]  o_register_rd;
  logic        o_ctl_reg_write, o_ctl_mem_read, o_ctl_mem_write, o_ctl_mem_to_reg;
  logic [1:0]  o_ctl_mem_size;
  logic        o_ctl_mem_unsigned, o_halt, o_halt_drained;

  int   errors = 0;
  int   checks = 0;
  out_t exp_q[$];
  out_t last_exp = '0;

  always #5 i_clk = ~i_clk;

  latch_ex_mem #(.BITS_SIZE(32), .BITS_REGS(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_valid(i_valid), .i_alu_result(i_alu_result), .i_store_data(i_store_data),
    .i_mux_register_rd(i_mux_register_rd), .i_ctl_reg_write(i_ctl_reg_write),
    .i_ctl_mem_read(i_ctl_mem_read), .i_ctl_mem_write(i_ctl_mem_write),
    .i_ctl_mem_to_reg(i_ctl_mem_to_reg), .i_ctl_mem_size(i_ctl_mem_size),
    .i_ctl_mem_unsigned(i_ctl_mem_unsigned), .i_halt(i_halt),
    .o_valid(o_valid), .o_alu_result(o_alu_result), .o_store_data(o_store_data),
    .o_register_rd(o_register_rd), .o_ctl_reg_write(o_ctl_reg_write),
    .o_ctl_mem_read(o_ctl_mem_read), .o_ctl_mem_write(o_ctl_mem_write),
    .o_ctl_mem_to_reg(o_ctl_mem_to_reg), .o_ctl_mem_size(o_ctl_mem_size),
    .o_ctl_mem_unsigned(o_ctl_mem_unsigned), .o_halt(o_halt),
    .o_halt_drained(o_halt_drained)
  );

  task automatic set_instr(input logic v, input logic [31:0] alu, input logic [31:0] st,
                           input logic [4:0] rd, input logic [6:0] ctl, input logic h);
    i_valid = v; i_alu_result = alu; i_store_data = st; i_mux_register_rd = rd;
    {i_ctl_reg_write, i_ctl_mem_read, i_ctl_mem_write, i_ctl_mem_to_reg,
     i_ctl_mem_size, i_ctl_mem_unsigned} = ctl;
    i_halt = h;
  endtask

  // Expected outputs follow the latch rules directly from the driven inputs; drain flag is given per step.
  task automatic cycle(input logic exp_drained, input string tag);
    out_t e;
    out_t got;
    e = '0;
    if (i_reset) begin
      e = '0;
    end else if (!i_enable) begin
      e = last_exp;
    end else if (!i_flush) begin
      e.valid = i_valid;
      e.alu   = i_alu_result;
      e.store = i_store_data;
      e.rd    = i_mux_register_rd;
      if (i_valid) begin
        e.rw   = i_ctl_reg_write && (i_mux_register_rd != 5'd0);
        e.mr   = i_ctl_mem_read && !i_ctl_mem_write;
        e.mw   = i_ctl_mem_write && !i_ctl_mem_read;
        e.m2r  = i_ctl_mem_to_reg;
        e.size = (i_ctl_mem_size == 2'b10) ? 2'b11 : i_ctl_mem_size;
        e.uns  = i_ctl_mem_unsigned;
        e.halt = i_halt;
      end
    end
    e.drained = exp_drained;
    exp_q.push_back(e);
    last_exp = e;
    @(posedge i_clk);
    #1;
    got = {o_valid, o_alu_result, o_store_data, o_register_rd, o_ctl_reg_write,
           o_ctl_mem_read, o_ctl_mem_write, o_ctl_mem_to_reg, o_ctl_mem_size,
           o_ctl_mem_unsigned, o_halt, o_halt_drained};
    e = exp_q.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, e);
    end
  endtask

  initial begin
    // ctl vector order: reg_write, mem_read, mem_write, mem_to_reg, size[1:0], unsigned
    i_reset = 1'b1; i_enable = 1'b1; i_flush = 1'b1;
    set_instr(1'b1, 32'hFFFF_FFFF, 32'hAAAA_5555, 5'd31, 7'b1111111, 1'b1);
    cycle(1'b0, "reset_all_inputs_set");
    i_reset = 1'b0; i_flush = 1'b0;

    set_instr(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 5'd5, 7'b1000_110, 1'b0);
    cycle(1'b0, "load_basic");
    set_instr(1'b1, 32'h0000_2000, 32'h0, 5'd0, 7'b1101_001, 1'b0);
    cycle(1'b0, "zero_reg_write_dropped");
    set_instr(1'b0, 32'h1234_5678, 32'h8765_4321, 5'd9, 7'b1011_111, 1'b1);
    cycle(1'b0, "invalid_gates_ctl");
    set_instr(1'b1, 32'hCAFE_0000, 32'h0000_00FF, 5'd7, 7'b1000_111, 1'b0);
    cycle(1'b0, "load_before_hold");

    i_enable = 1'b0; i_flush = 1'b1;
    set_instr(1'b1, 32'h1111_1111, 32'h2222_2222, 5'd3, 7'b1111_111, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, "hold_ignores_flush");
    i_enable = 1'b1;
    cycle(1'b0, "flush_bubble");
    i_flush = 1'b0;

    set_instr(1'b1, 32'h0000_4000, 32'h0000_BEEF, 5'd4, 7'b0110_100, 1'b0);
    cycle(1'b0, "ld_st_conflict_size10");
    set_instr(1'b1, 32'h0000_4002, 32'h0000_ABCD, 5'd4, 7'b0010_010, 1'b0);
    cycle(1'b0, "store_half");

    set_instr(1'b1, 32'h0, 32'h0, 5'd0, 7'b0000_000, 1'b1);
    cycle(1'b0, "halt_capture");
    set_instr(1'b1, 32'h10, 32'h0, 5'd2, 7'b1000_110, 1'b0);
    cycle(1'b0, "halt_drain_1");
    cycle(1'b1, "halt_drain_done");
    cycle(1'b1, "halt_drained_sticky");
    i_reset = 1'b1;
    cycle(1'b0, "reset_clears_drained");
    i_reset = 1'b0;

    set_instr(1'b1, 32'h0, 32'h0, 5'd0, 7'b0000_000, 1'b1);
    cycle(1'b0, "halt_capture_en");
    set_instr(1'b1, 32'h20, 32'h0, 5'd6, 7'b1000_110, 1'b0);
    i_enable = 1'b0; cycle(1'b0, "halt_drain_frozen_a");
    i_enable = 1'b1; cycle(1'b0, "halt_drain_en_1");
    i_enable = 1'b0; cycle(1'b0, "halt_drain_frozen_b");
    i_enable = 1'b1; cycle(1'b1, "halt_drain_en_done");
    i_reset = 1'b1; cycle(1'b0, "reset_after_toggle");
    i_reset = 1'b0;

    set_instr(1'b1, 32'h0, 32'h0, 5'd0, 7'b0000_000, 1'b1);
    cycle(1'b0, "halt_capture_mid");
    i_reset = 1'b1; set_instr(1'b1, 32'h30, 32'h0, 5'd8, 7'b1000_110, 1'b0);
    cycle(1'b0, "reset_mid_drain");
    i_reset = 1'b0;
    cycle(1'b0, "after_mid_reset_1");
    cycle(1'b0, "after_mid_reset_2");

    set_instr(1'b1, 32'h0, 32'h0, 5'd0, 7'b0000_000, 1'b1);
    i_flush = 1'b1;
    cycle(1'b0, "halt_flushed");
    i_flush = 1'b0; set_instr(1'b1, 32'h40, 32'h0, 5'd1, 7'b1000_110, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, "flushed_halt_never_drains");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
